instr_loader_fsm: RTL and testbench

Parametrised debug loader for the MIPS pipeline. It pops bytes from the UART receive FIFO and assembles them MSB-first into NB_DATA-bit instruction words. Each word is written to consecutive instruction-memory addresses until the halt word arrives or memory fills; a mode byte then starts the pipeline in continuous or single-step mode. It sits between the UART RX FIFO and `top_pipeline`, and generalises the fixed 32-bit/4-byte, run-only load flow.

---
 rtl/instr_loader_fsm_pkg.sv | 20 ++
 rtl/instr_loader_fsm_if.sv | 26 ++
 rtl/instr_loader_fsm_byte_assembler.sv | 48 ++++
 rtl/instr_loader_fsm.sv | 139 +++++++++++++
 tb/tb_instr_loader_fsm.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_loader_fsm_pkg.sv
// Shared types and constants for the UART instruction loader.
// State encoding, mode codes and the default terminator word.
package loader_pkg;

   typedef enum logic [2:0] {
      ST_LOAD      = 3'd0,
      ST_WRITE     = 3'd1,
      ST_SEL_MODE  = 3'd2,
      ST_RUN       = 3'd3,
      ST_STEP_WAIT = 3'd4,
      ST_STEP      = 3'd5,
      ST_DONE      = 3'd6
   } state_e;

   localparam logic [7:0] MODE_CONT = 8'h01;
   localparam logic [7:0] MODE_STEP = 8'h02;

   localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

endpackage

// File: rtl/instr_loader_fsm_if.sv
// Loader bus: UART RX FIFO pop side plus instruction-memory write port.
// slave = loader, master = FIFO/memory side.
interface instr_loader_fsm_if #(
   parameter int NB_DATA = 32,
   parameter int NB_BYTE = 8,
   parameter int NB_ADDR = 7
);

   logic [NB_BYTE-1:0] rx_data;
   logic               rx_empty;
   logic               rx_read;
   logic               imem_wr_en;
   logic [NB_ADDR-1:0] imem_addr;
   logic [NB_DATA-1:0] imem_data;

   modport slave (
      input  rx_data, rx_empty,
      output rx_read, imem_wr_en, imem_addr, imem_data
   );

   modport master (
      output rx_data, rx_empty,
      input  rx_read, imem_wr_en, imem_addr, imem_data
   );

endinterface

// File: rtl/instr_loader_fsm_byte_assembler.sv
// MSB-first byte-to-word shift register with a byte counter.
// word_valid_o flags the shift that completes a word.
module byte_assembler #(
   parameter int NB_DATA = 32,
   parameter int NB_BYTE = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               clr_i,
   input  logic               shift_i,
   input  logic [NB_BYTE-1:0] byte_i,
   output logic [NB_DATA-1:0] word_o,
   output logic               word_valid_o
);

   localparam int NB_WORDS = NB_DATA / NB_BYTE;
   localparam int NB_CNT   = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1;
   localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(NB_WORDS - 1);

   logic [NB_DATA-1:0] word_q, word_d;
   logic [NB_CNT-1:0]  cnt_q, cnt_d;

   always_comb begin
      word_d = word_q;
      cnt_d  = cnt_q;
      if (clr_i) begin
         word_d = '0;
         cnt_d  = '0;
      end else if (shift_i) begin
         word_d = (word_q << NB_BYTE) | NB_DATA'(byte_i);
         cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + NB_CNT'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else begin
         word_q <= word_d;
         cnt_q  <= cnt_d;
      end
   end

   assign word_o       = word_q;
   assign word_valid_o = shift_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/instr_loader_fsm.sv
// UART debug loader: assembles words into instruction memory, then runs/steps.
// Optional LOADER_CHECKSUM_EN builds an XOR checksum of all written words.
module instr_loader_fsm
   import loader_pkg::*;
#(
   parameter int                 NB_DATA   = 32,
   parameter int                 NB_BYTE   = 8,
   parameter int                 NB_ADDR   = 7,
   parameter logic [NB_DATA-1:0] HALT_WORD = '1
) (
   input  logic               clock,
   input  logic               reset,
   instr_loader_fsm_if.slave  bus,
   input  logic               halt_i,
   output logic               pipe_en,
   output logic [2:0]         state_o,
   output logic               overflow_o,
   output logic [NB_DATA-1:0] checksum_o
);

   localparam logic [NB_ADDR-1:0] ADDR_LAST = '1;

   state_e             state_q, state_d;
   logic [NB_ADDR-1:0] ptr_q, ptr_d;
   logic               ovf_q, ovf_d;
   logic               rd, wr, shift, clr, word_valid;
   logic [NB_DATA-1:0] word;

   byte_assembler #(
      .NB_DATA (NB_DATA),
      .NB_BYTE (NB_BYTE)
   ) u_asm (
      .clock        (clock),
      .reset        (reset),
      .clr_i        (clr),
      .shift_i      (shift),
      .byte_i       (bus.rx_data),
      .word_o       (word),
      .word_valid_o (word_valid)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      ovf_d   = ovf_q;
      rd      = 1'b0;
      wr      = 1'b0;
      shift   = 1'b0;
      clr     = 1'b0;
      pipe_en = 1'b0;
      unique case (state_q)
         ST_LOAD: begin
            rd    = !bus.rx_empty;
            shift = rd;
            if (word_valid) state_d = ST_WRITE;
         end
         ST_WRITE: begin
            wr = 1'b1;
            if (word == HALT_WORD) begin
               state_d = ST_SEL_MODE;
            end else if (ptr_q == ADDR_LAST) begin
               ovf_d   = 1'b1;
               state_d = ST_SEL_MODE;
            end else begin
               ptr_d   = ptr_q + NB_ADDR'(1);
               state_d = ST_LOAD;
            end
         end
         ST_SEL_MODE: begin
            rd = !bus.rx_empty;
            // Unknown mode bytes are popped and dropped.
            if (rd && bus.rx_data == NB_BYTE'(MODE_CONT))
               state_d = ST_RUN;
            else if (rd && bus.rx_data == NB_BYTE'(MODE_STEP))
               state_d = ST_STEP_WAIT;
         end
         ST_RUN: begin
            pipe_en = 1'b1;
            if (halt_i) state_d = ST_DONE;
         end
         ST_STEP_WAIT: begin
            rd = !bus.rx_empty;
            if (rd) state_d = ST_STEP;
         end
         ST_STEP: begin
            pipe_en = 1'b1;
            state_d = halt_i ? ST_DONE : ST_STEP_WAIT;
         end
         ST_DONE: begin
            rd = !bus.rx_empty;
            if (rd) begin
               clr     = 1'b1;
               ptr_d   = '0;
               state_d = ST_LOAD;
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_LOAD;
         ptr_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.rx_read    = rd;
   assign bus.imem_wr_en = wr;
   assign bus.imem_addr  = ptr_q;
   assign bus.imem_data  = wr ? word : '0;
   assign state_o        = state_q;
   assign overflow_o     = ovf_q;

`ifdef LOADER_CHECKSUM_EN
   logic [NB_DATA-1:0] ck_q, ck_d;

   always_comb begin
      ck_d = ck_q;
      if (wr)  ck_d = ck_q ^ word;
      if (clr) ck_d = '0;
   end

   always_ff @(posedge clock) begin
      if (reset) ck_q <= '0;
      else       ck_q <= ck_d;
   end

   assign checksum_o = ck_q;
`else
   assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_instr_loader_fsm.sv
// Self-checking bench for instr_loader_fsm with a queue-based FIFO and load model.
// Depth is reduced to four words so the overflow path is reachable quickly.
module tb_instr_loader_fsm;
   import loader_pkg::*;

   localparam int          NA    = 2;
   localparam int          DEPTH = 1 << NA;
   localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        halt_i = 1'b0;
   logic        pipe_en;
   logic [2:0]  state_o;
   logic        overflow_o;
   logic [31:0] checksum_o;

   always #5 clock = ~clock;

   instr_loader_fsm_if #(.NB_DATA(32), .NB_BYTE(8), .NB_ADDR(NA)) bus ();

   instr_loader_fsm #(.NB_DATA(32), .NB_BYTE(8), .NB_ADDR(NA)) dut (
      .clock      (clock),
      .reset      (reset),
      .bus        (bus),
      .halt_i     (halt_i),
      .pipe_en    (pipe_en),
      .state_o    (state_o),
      .overflow_o (overflow_o),
      .checksum_o (checksum_o)
   );

   logic [7:0]    fifo[$];
   bit            stall_en = 1'b0;
   bit            stall = 1'b0;
   int            pops = 0;
   int            pulses = 0;
   logic [NA-1:0] wa[$];
   logic [31:0]   wd[$];

   logic [NA-1:0] ea[$];
   logic [31:0]   ed[$];
   logic [31:0]   words[$];
   logic [31:0]   m_ck;
   bit            m_ovf;

   int total = 0;
   int bad = 0;

   // FIFO head becomes visible just after the falling edge
   always @(negedge clock) begin
      #1;
      stall = stall_en ? ~stall : 1'b0;
      bus.rx_empty = (fifo.size() == 0) || stall;
      bus.rx_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
   end

   always @(posedge clock) begin
      if (bus.rx_read && !bus.rx_empty) begin
         void'(fifo.pop_front());
         pops++;
      end
      if (bus.imem_wr_en) begin
         wa.push_back(bus.imem_addr);
         wd.push_back(bus.imem_data);
      end
      if (pipe_en) pulses++;
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_ck();
`ifdef LOADER_CHECKSUM_EN
      return m_ck;
`else
      return 32'h0;
`endif
   endfunction

   function automatic logic [31:0] rnd_word();
      logic [31:0] w;
      w = $urandom;
      if (w == HALT) w = 32'h0;
      return w;
   endfunction

   task automatic wait_state(input logic [2:0] s, input string tag);
      int n = 0;
      while (state_o !== s && n < 300) begin
         @(negedge clock);
         n++;
      end
      chk(tag, state_o, s);
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while (fifo.size() != 0 && n < 300) begin
         @(negedge clock);
         n++;
      end
      chk(tag, fifo.size(), 0);
   endtask

   // Queue every word MSB-first; expected writes stop at halt or full memory
   task automatic load(input logic [7:0] mode, input bit with_mode);
      bit fin = 1'b0;
      ea.delete(); ed.delete(); wa.delete(); wd.delete();
      foreach (words[i]) begin
         for (int b = 3; b >= 0; b--) fifo.push_back(words[i][8*b +: 8]);
         if (!fin) begin
            ea.push_back(NA'(i));
            ed.push_back(words[i]);
            m_ck ^= words[i];
            if (words[i] == HALT) begin
               fin = 1'b1;
            end else if (i == DEPTH - 1) begin
               m_ovf = 1'b1;
               fin = 1'b1;
            end
         end
      end
      if (with_mode) fifo.push_back(mode);
   endtask

   task automatic check_writes(input string tag);
      chk({tag, "_nwr"}, wa.size(), ea.size());
      for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
         chk({tag, "_addr"}, wa[i], ea[i]);
         chk({tag, "_data"}, wd[i], ed[i]);
      end
   endtask

   task automatic restart();
      fifo.push_back(8'($urandom));
      wait_state(ST_LOAD, "restart_load");
      m_ck = 32'h0;
   endtask

   initial begin
      int base;
      m_ck  = 32'h0;
      m_ovf = 1'b0;

      repeat (2) @(negedge clock);
      chk("rst_rx_read", bus.rx_read, 1'b0);
      chk("rst_wr_en", bus.imem_wr_en, 1'b0);
      chk("rst_addr", bus.imem_addr, 0);
      chk("rst_data", bus.imem_data, 0);
      chk("rst_pipe_en", pipe_en, 1'b0);
      chk("rst_state", state_o, ST_LOAD);
      chk("rst_ovf", overflow_o, 1'b0);
      chk("rst_ck", checksum_o, 0);
      reset = 1'b0;

      words = '{32'h0000_2380, HALT};
      load(MODE_CONT, 1'b1);
      wait_drain("t1_drain");
      chk("t1_state_run", state_o, ST_RUN);
      chk("t1_pipe_rise", pipe_en, 1'b1);
      check_writes("t1");
      chk("t1_ovf", overflow_o, m_ovf);
      chk("t1_ck", checksum_o, exp_ck());
      halt_i = 1'b1;
      @(negedge clock);
      halt_i = 1'b0;
      chk("t1_done", state_o, ST_DONE);
      chk("t1_pipe_off", pipe_en, 1'b0);

      restart();
      words = '{32'h1234_5678, HALT};
      load(MODE_STEP, 1'b1);
      wait_state(ST_STEP_WAIT, "t2_step_wait");
      check_writes("t2");
      chk("t2_ck", checksum_o, exp_ck());
      base = pulses;
      for (int i = 0; i < 3; i++) begin
         int n = 0;
         fifo.push_back(8'($urandom));
         while (pipe_en !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
         end
         chk("t2_pulse", pipe_en, 1'b1);
         chk("t2_state_step", state_o, ST_STEP);
         if (i == 2) halt_i = 1'b1;
         @(negedge clock);
         halt_i = 1'b0;
         chk("t2_pulse_end", pipe_en, 1'b0);
         chk("t2_after", state_o, (i == 2) ? ST_DONE : ST_STEP_WAIT);
      end
      repeat (3) @(negedge clock);
      chk("t2_npulses", pulses - base, 3);

      restart();
      fifo.push_back(8'($urandom));
      fifo.push_back(8'($urandom));
      wait_drain("t3_partial");
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      m_ck  = 32'h0;
      m_ovf = 1'b0;
      chk("t3_rst_state", state_o, ST_LOAD);
      chk("t3_rst_addr", bus.imem_addr, 0);
      words = '{rnd_word(), HALT};
      load(MODE_CONT, 1'b1);
      wait_drain("t3_drain");
      chk("t3_run", state_o, ST_RUN);
      check_writes("t3");
      chk("t3_ck", checksum_o, exp_ck());
      halt_i = 1'b1;
      @(negedge clock);
      halt_i = 1'b0;
      chk("t3_done", state_o, ST_DONE);

      restart();
      words.delete();
      for (int i = 0; i < DEPTH; i++) words.push_back(rnd_word());
      words.push_back(32'h5555_5555);
      load(8'h00, 1'b0);
      wait_state(ST_SEL_MODE, "t4_sel");
      chk("t4_fifth_unpopped", fifo.size(), 4);
      chk("t4_ovf", overflow_o, m_ovf);
      check_writes("t4");
      wait_drain("t4_drain");
      chk("t4_still_sel", state_o, ST_SEL_MODE);
      chk("t4_nwr_final", wa.size(), DEPTH);
      chk("t4_ck", checksum_o, exp_ck());
      fifo.push_back(MODE_CONT);
      wait_state(ST_RUN, "t4_run");
      halt_i = 1'b1;
      @(negedge clock);
      halt_i = 1'b0;
      chk("t4_done", state_o, ST_DONE);

      restart();
      chk("t5_ovf_sticky", overflow_o, m_ovf);
      stall_en = 1'b1;
      base = pops;
      words.delete();
      for (int i = 0; i < 1 + int'($urandom_range(1)); i++)
         words.push_back(rnd_word());
      words.push_back(HALT);
      load(MODE_CONT, 1'b1);
      wait_state(ST_RUN, "t5_run");
      stall_en = 1'b0;
      check_writes("t5");
      chk("t5_pops", pops - base, 4 * words.size() + 1);
      chk("t5_ck", checksum_o, exp_ck());

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
